// File: rtl/flap_ctrl.sv
// Flap game controller: synchronises the flap key, generates the game-step strobe
// and sequences IDLE -> RUN -> OVER for the bird-column light cells.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for the first press; divider held at 0
// S_RUN  | game running; presses queue a flap, collision ends game
// S_OVER | game over; strobes continue, up forced low, reset only exit
module flap_ctrl #(
    parameter int TICK_DIV   = 12_500_000,
    parameter int FLAP_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic collision,
    output logic enable,
    output logic up,
    output logic gameOver
);
    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int FLAP_W = $clog2(FLAP_TICKS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [FLAP_W-1:0] FLAP_LOAD = FLAP_W'(FLAP_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_sync1, r_sync2, r_hist;
    logic [DIV_W-1:0]    r_div, w_div_nxt;
    logic [FLAP_W-1:0]   r_flap, w_flap_nxt;
    logic                r_req, w_req_nxt;
    logic                w_press_edge;
    logic                w_tick;

    // Flops reset to the released level so no press is seen coming out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_press_edge = ~r_sync2 & r_hist;
    assign w_tick       = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_flap  <= '0;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_flap  <= w_flap_nxt;
            r_req   <= w_req_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_flap_nxt  = r_flap;
        w_req_nxt   = r_req;
        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                if (w_press_edge) begin
                    w_state_nxt = S_RUN;
                    w_req_nxt   = 1'b1;
                end
            end
            S_RUN: begin
                w_div_nxt = w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    if (r_req) begin
                        w_flap_nxt = FLAP_LOAD;
                        w_req_nxt  = 1'b0;
                    end else if (r_flap != '0) begin
                        w_flap_nxt = r_flap - 1'b1;
                    end
                end
                // Set after the tick's clear so a coincident press is served next tick.
                if (w_press_edge) begin
                    w_req_nxt = 1'b1;
                end
                if (collision) begin
                    w_state_nxt = S_OVER;
                end
            end
            S_OVER: begin
                w_div_nxt  = w_tick ? '0 : r_div + 1'b1;
                w_flap_nxt = '0;
                w_req_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = '0;
                w_flap_nxt  = '0;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign enable   = w_tick & (r_state != S_IDLE);
    assign up       = (r_flap != '0) & (r_state != S_OVER);
    assign gameOver = (r_state == S_OVER);
endmodule

// File: tb/tb_flap_ctrl.sv
// Bench for flap_ctrl: spec-timed vector table, hand sequences for the corner cases,
// and random key/collision/reset traffic against a cycle-count reference model.
module tb_flap_ctrl;
    localparam int TD = 4;
    localparam int FT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_n = 1'b1;
    logic collision = 1'b0;
    logic enable, up, gameOver;

    flap_ctrl #(.TICK_DIV(TD), .FLAP_TICKS(FT)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .collision(collision),
        .enable(enable), .up(up), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game mode, cycles elapsed since the game started, flap steps left,
    // a pending-flap request, and the history of sampled key levels (newest first).
    int m_mode;
    int m_elapsed;
    int m_steps;
    bit m_req;
    bit m_samp[$];

    function automatic void model_reset();
        m_mode = 0; m_elapsed = 0; m_steps = 0; m_req = 0;
        m_samp = '{1'b1, 1'b1, 1'b1};
    endfunction

    function automatic bit m_enable();
        return (m_mode != 0) && ((m_elapsed % TD) == TD - 1);
    endfunction
    function automatic bit m_up();
        return (m_mode == 1) && (m_steps > 0);
    endfunction
    function automatic bit m_go();
        return m_mode == 2;
    endfunction

    function automatic void model_update(input bit k, input bit c);
        bit press;
        bit tick;
        press = !m_samp[1] && m_samp[2];
        tick  = m_enable();
        if (m_mode == 0) begin
            if (press) begin
                m_mode = 1; m_elapsed = 0; m_req = 1;
            end
        end else if (m_mode == 1) begin
            if (tick) begin
                if (m_req) begin
                    m_steps = FT; m_req = 0;
                end else if (m_steps > 0) begin
                    m_steps--;
                end
            end
            if (press) m_req = 1;
            m_elapsed++;
            if (c) begin
                m_mode = 2; m_steps = 0; m_req = 0;
            end
        end else begin
            m_elapsed++;
        end
        m_samp.push_front(k);
        void'(m_samp.pop_back());
    endfunction

    task automatic step(input bit k, input bit c);
        key_n = k;
        collision = c;
        model_update(k, c);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit key;
        bit col;
        bit en;
        bit up;
        bit go;
    } vec_t;
    vec_t tbl[20];

    task automatic run_table();
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].key, tbl[i].col);
            check("tbl_enable", enable, tbl[i].en);
            check("tbl_up", up, tbl[i].up);
            check("tbl_gameOver", gameOver, tbl[i].go);
        end
    endtask

    initial begin
        bit found;
        int hold;
        bit k;

        // Press at edge 0 (k=0): RUN at edge 2, strobes after edges 5,9,13,17; up from 6 to 13.
        for (int i = 0; i < 20; i++) begin
            tbl[i].key = (i < 6) ? 1'b0 : 1'b1;
            tbl[i].col = 1'b0;
            tbl[i].en  = (i >= 5) && (((i - 5) % 4) == 0);
            tbl[i].up  = (i >= 6) && (i <= 13);
            tbl[i].go  = 1'b0;
        end

        model_reset();
        #3;
        check("rst_enable", enable, 1'b0);
        check("rst_up", up, 1'b0);
        check("rst_gameOver", gameOver, 1'b0);
        #4 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0);
            check("idle_enable", enable, 1'b0);
            check("idle_up", up, 1'b0);
            check("idle_gameOver", gameOver, 1'b0);
        end

        run_table();

        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            step(1'b1, 1'b0);
            if (enable) found = 1'b1;
        end
        check("find_tick", found, 1'b1);

        // j counts edges after the strobe just found.
        for (int j = 1; j <= 28; j++) begin
            step(((j >= 3 && j <= 5) || j == 14 || j == 15) ? 1'b0 : 1'b1, 1'b0);
            case (j)
                4:  check("coinc_tick_enable", enable, 1'b1);
                5:  check("coinc_up_unchanged", up, 1'b0);
                8:  check("coinc_next_up_still0", up, 1'b0);
                9:  check("coinc_up_rise", up, 1'b1);
                16: check("ext_enable", enable, 1'b1);
                17: check("ext_reload_up", up, 1'b1);
                21: check("ext_up_step2", up, 1'b1);
                24: check("ext_up_last", up, 1'b1);
                25: check("ext_up_fall", up, 1'b0);
                28: begin
                    check("col_tick_enable", enable, 1'b1);
                    check("col_tick_gameOver", gameOver, 1'b0);
                end
                default: ;
            endcase
        end
        step(1'b1, 1'b1);
        check("over_gameOver", gameOver, 1'b1);
        check("over_up", up, 1'b0);
        check("over_enable", enable, 1'b0);
        for (int j = 30; j <= 41; j++) begin
            step((j >= 31 && j <= 34) ? 1'b0 : 1'b1, j[0]);
            check("over_enable_period", enable, (j % 4) == 0);
            check("over_hold_gameOver", gameOver, 1'b1);
            check("over_press_ignored", up, 1'b0);
        end

        #3 reset = 1'b1;
        #1;
        check("async_rst_gameOver", gameOver, 1'b0);
        check("async_rst_enable", enable, 1'b0);
        check("async_rst_up", up, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        run_table();

        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        hold = 0;
        k = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (hold == 0) begin
                k = $urandom_range(0, 1);
                hold = $urandom_range(1, 9);
            end
            hold--;
            step(k, $urandom_range(0, 149) == 0);
            check("rnd_enable", enable, m_enable());
            check("rnd_up", up, m_up());
            check("rnd_gameOver", gameOver, m_go());
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check("rnd_rst_gameOver", gameOver, 1'b0);
                reset = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
